lcd_sequencer: RTL and testbench
================================

# lcd_sequencer

Command/character sequencer directly upstream of `enabler`: it drives `go`, `rs_in` and the 8-bit LCD data bus, and waits for `en_done` before moving on. After reset it issues the HD44780 power-up initialisation sequence. It then accepts ASCII bytes from the PS/2 decode path through a valid/ready handshake and writes them to a 2×16 display, handling cursor line changes and wrap-around.

## Interface
Parameters:
- `POWERUP_CYCLES`, default 750000: idle cycles after reset before the first command.
- `CMD_WAIT_CYCLES`, default 2000: post-`en_done` settle time for normal commands and characters.
- `CLEAR_WAIT_CYCLES`, default 82000: post-`en_done` settle time after the clear command (0x01).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `char_valid`  in  1  upstream byte available.
- `char_data`  in  8  ASCII byte.
- `char_ready`  out  1  sequencer can accept a byte this cycle.
- `go`  out  1  request to `enabler`; held until `en_done` is sampled.
- `rs_in`  out  1  register select to `enabler`: 0 = command, 1 = data.
- `lcd_data`  out  8  byte on the LCD bus.
- `en_done`  in  1  `enabler` transfer complete.
- `init_done`  out  1  high once initialisation has finished.

## Operation
- Reset values: `go`=0, `rs_in`=0, `lcd_data`=0x00, `char_ready`=0, `init_done`=0. Column counter is 0 and state is S_POWERUP.
- States:
  - S_POWERUP: count `POWERUP_CYCLES`, then go to S_ISSUE.
  - S_ISSUE: assert `go` with `rs_in`/`lcd_data` taken from the pending op, then go to S_WAIT.
  - S_WAIT: hold all three outputs stable. On `en_done`=1, drop `go` and load the delay. Go to S_DELAY.
  - S_DELAY: count the delay down. Then go to the next init op, or to S_IDLE.
  - S_IDLE: `char_ready`=1.
- Init ops, in order, all with `rs_in`=0: 0x38, 0x0C, 0x06, 0x01. The 0x01 op uses `CLEAR_WAIT_CYCLES`. `init_done` rises on entry to S_IDLE and stays high until reset.
- Character accept (`char_valid && char_ready` in S_IDLE):
  - Column 16: first issue a command 0xC0, then the character.
  - Column 32: first issue a command 0x80 and reset the column to 0, then the character.
  - Character write uses `rs_in`=1 and `lcd_data`=`char_data`, latched at acceptance.
  - Column increments after the character's `en_done`.
- `en_done` while `go`=0 is ignored.
- Column counter is 6 bits. Valid range is 0..32; it is never allowed past 32.

## Timing
- Accept at edge N: `char_ready`=0 from N+1 and `go`=1 from N+1.
- `en_done` sampled at edge M: `go`=0 from M+1. The delay runs for exactly `CMD_WAIT_CYCLES` (or `CLEAR_WAIT_CYCLES`) cycles. `char_ready` returns the cycle after the count expires.
- `rs_in`/`lcd_data` change only on the cycle `go` rises. They are stable for as long as `go`=1.
- `rst` asserted mid-transfer: all outputs return to reset values at the next edge and the full power-up sequence restarts.
- `char_valid` while not ready: the byte is not consumed. Upstream must hold it.

## Configuration
- `LCD_SEQ_CTRL_CHARS_EN` defined:
  - 0x0D: issues 0x80 or 0xC0, whichever moves to the start of the other line, and sets the column to 0 or 16. No character write.
  - 0x0C: issues 0x01 with `CLEAR_WAIT_CYCLES` and sets the column to 0.
- Undefined: every byte, including 0x0C and 0x0D, is written as a character.

## Structure
- `lcd_pkg`: command constants (`LCD_FUNC_SET`=0x38, `LCD_DISP_ON`=0x0C, `LCD_ENTRY`=0x06, `LCD_CLEAR`=0x01, `LCD_LINE1`=0x80, `LCD_LINE2`=0xC0), the state enum, and the column limits 16/32.
- Sub-module `lcd_delay_timer`: loadable down-counter with load/value/expired. Shared by S_POWERUP and S_DELAY.

## Test plan
Bench parameters: `POWERUP_CYCLES`=20, `CMD_WAIT_CYCLES`=4, `CLEAR_WAIT_CYCLES`=8. The bench models `enabler` by returning a 1-cycle `en_done` 3 cycles after `go` rises.
- Reset release -> no `go` for 20 cycles. Then `go` transfers 0x38, 0x0C, 0x06, 0x01 with `rs_in`=0. Gaps are 4, 4, 4 and 8 cycles. `init_done`=1 after the last gap.
- Send 0x41 -> `go` the next cycle with `rs_in`=1, `lcd_data`=0x41. `char_ready` is back 4 cycles after `en_done`.
- Send 17 bytes -> the 17th is preceded by a command 0xC0.
- Send 33 bytes -> the 33rd is preceded by a command 0x80. The 34th has no address command.
- Assert `rst` while `go`=1 -> next cycle `go`=0, `init_done`=0, and the power-up restarts.
- With `LCD_SEQ_CTRL_CHARS_EN`: 0x0C -> command 0x01 with an 8-cycle wait. Then 0x0D -> command 0xC0 with no data write.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and op descriptor for the HD44780 command/character sequencer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_FF = 8'h0C;

  localparam logic [5:0] COL_LINE2 = 6'd16;
  localparam logic [5:0] COL_END   = 6'd32;

  localparam logic [2:0] INIT_OPS = 3'd4;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_ISSUE,
    S_WAIT,
    S_DELAY,
    S_IDLE
  } lcd_state_e;

  // What a newly accepted byte turns into on the bus, plus any column side effect.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       clear;
    logic       pend;
    logic       col_load;
    logic [5:0] col_val;
  } lcd_op_t;

  function automatic logic [7:0] init_op(input logic [2:0] idx);
    case (idx)
      3'd0:    init_op = LCD_FUNC_SET;
      3'd1:    init_op = LCD_DISP_ON;
      3'd2:    init_op = LCD_ENTRY;
      default: init_op = LCD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter used for both the power-up wait and the post-transfer settle time.
module lcd_delay_timer #(
  parameter int               WIDTH   = 20,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             count_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  // Expiry is flagged on the last counted cycle so a load of N spans exactly N cycles.
  assign expired_o = (count_q[WIDTH-1:1] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_i && !expired_o) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 init + character sequencer feeding the enabler handshake.
// Define LCD_SEQ_CTRL_CHARS_EN to treat 0x0D as line switch and 0x0C as clear screen.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       go,
  output logic       rs_in,
  output logic [7:0] lcd_data,
  input  logic       en_done,
  output logic       init_done
);

  // state     | meaning
  // S_POWERUP | waiting out the supply ramp before the first command
  // S_ISSUE   | go just raised with the pending op
  // S_WAIT    | holding go/rs_in/lcd_data until en_done
  // S_DELAY   | settle time after a completed transfer
  // S_IDLE    | init finished, char_ready high

  localparam int MAX_A   = (POWERUP_CYCLES > CMD_WAIT_CYCLES) ? POWERUP_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_CYC = (MAX_A > CLEAR_WAIT_CYCLES) ? MAX_A : CLEAR_WAIT_CYCLES;
  localparam int TMR_W   = (MAX_CYC < 2) ? 2 : $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] PWR_VAL = TMR_W'(POWERUP_CYCLES);
  localparam logic [TMR_W-1:0] CMD_VAL = TMR_W'(CMD_WAIT_CYCLES);
  localparam logic [TMR_W-1:0] CLR_VAL = TMR_W'(CLEAR_WAIT_CYCLES);

  lcd_state_e state_q;
  logic       go_q, rs_q, ready_q, init_done_q, pend_q, clear_q;
  logic [7:0] data_q, char_q;
  logic [5:0] col_q;
  logic [2:0] init_idx_q;

  logic       tmr_expired, tmr_count, xfer_done;
  logic [7:0] init_byte;
  lcd_op_t    acc_op;

  assign char_ready = ready_q;
  assign go         = go_q;
  assign rs_in      = rs_q;
  assign lcd_data   = data_q;
  assign init_done  = init_done_q;

  assign xfer_done = go_q && en_done;
  assign tmr_count = (state_q == S_POWERUP) || (state_q == S_DELAY);
  assign init_byte = init_op(init_idx_q);

  lcd_delay_timer #(
    .WIDTH  (TMR_W),
    .RST_VAL(PWR_VAL)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (xfer_done),
    .value_i  (clear_q ? CLR_VAL : CMD_VAL),
    .count_i  (tmr_count),
    .expired_o(tmr_expired)
  );

  always_comb begin
    acc_op         = '0;
    acc_op.rs      = 1'b1;
    acc_op.data    = char_data;
    acc_op.col_val = col_q;
`ifdef LCD_SEQ_CTRL_CHARS_EN
    if (char_data == CHR_CR) begin
      acc_op.rs       = 1'b0;
      acc_op.col_load = 1'b1;
      if (col_q < COL_LINE2) begin
        acc_op.data    = LCD_LINE2;
        acc_op.col_val = COL_LINE2;
      end else begin
        acc_op.data    = LCD_LINE1;
        acc_op.col_val = '0;
      end
    end else if (char_data == CHR_FF) begin
      acc_op.rs       = 1'b0;
      acc_op.data     = LCD_CLEAR;
      acc_op.clear    = 1'b1;
      acc_op.col_load = 1'b1;
      acc_op.col_val  = '0;
    end else
`endif
    if (col_q == COL_LINE2) begin
      acc_op.rs   = 1'b0;
      acc_op.data = LCD_LINE2;
      acc_op.pend = 1'b1;
    end else if (col_q >= COL_END) begin
      acc_op.rs       = 1'b0;
      acc_op.data     = LCD_LINE1;
      acc_op.pend     = 1'b1;
      acc_op.col_load = 1'b1;
      acc_op.col_val  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_POWERUP;
      go_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      col_q       <= '0;
      init_idx_q  <= '0;
      char_q      <= 8'h00;
      pend_q      <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      case (state_q)
        S_POWERUP: begin
          if (tmr_expired) begin
            go_q       <= 1'b1;
            rs_q       <= 1'b0;
            data_q     <= init_byte;
            clear_q    <= (init_byte == LCD_CLEAR);
            init_idx_q <= init_idx_q + 3'd1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (en_done) begin
            go_q    <= 1'b0;
            state_q <= S_DELAY;
            if (rs_q && (col_q < COL_END)) col_q <= col_q + 6'd1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_DELAY: begin
          if (tmr_expired) begin
            if (!init_done_q && (init_idx_q != INIT_OPS)) begin
              go_q       <= 1'b1;
              rs_q       <= 1'b0;
              data_q     <= init_byte;
              clear_q    <= (init_byte == LCD_CLEAR);
              init_idx_q <= init_idx_q + 3'd1;
              state_q    <= S_ISSUE;
            end else if (pend_q) begin
              // Address command done; now the character that was held back.
              go_q    <= 1'b1;
              rs_q    <= 1'b1;
              data_q  <= char_q;
              clear_q <= 1'b0;
              pend_q  <= 1'b0;
              state_q <= S_ISSUE;
            end else begin
              ready_q     <= 1'b1;
              init_done_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (char_valid && ready_q) begin
            ready_q <= 1'b0;
            go_q    <= 1'b1;
            rs_q    <= acc_op.rs;
            data_q  <= acc_op.data;
            clear_q <= acc_op.clear;
            pend_q  <= acc_op.pend;
            char_q  <= char_data;
            if (acc_op.col_load) col_q <= acc_op.col_val;
            state_q <= S_ISSUE;
          end
        end
        default: state_q <= S_POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a behavioural enabler (en_done 3 cycles after go rises).
module tb_lcd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready, go, rs_in, init_done, en_done;
  logic [7:0] lcd_data;
  logic       model_done = 1'b0;
  logic       spur = 1'b0;
  int         go_age = 0;
  int         tests = 0;
  int         fails = 0;

  assign en_done = model_done | spur;

  lcd_sequencer #(
    .POWERUP_CYCLES   (20),
    .CMD_WAIT_CYCLES  (4),
    .CLEAR_WAIT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .go        (go),
    .rs_in     (rs_in),
    .lcd_data  (lcd_data),
    .en_done   (en_done),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst || go !== 1'b1) begin
      go_age     = 0;
      model_done = 1'b0;
    end else begin
      go_age     = go_age + 1;
      model_done = (go_age == 3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts go-low negedges from the current one, then checks the op and its hold.
  task automatic expect_xfer(input string tag, input logic exp_rs, input logic [7:0] exp_data,
                             input int exp_gap);
    int n;
    int h;
    logic r;
    logic [7:0] d;
    logic stable;
    n = 0;
    while (go !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_gap"}, n, exp_gap);
    chk({tag, "_rs"}, {31'd0, rs_in}, {31'd0, exp_rs});
    chk({tag, "_data"}, {24'd0, lcd_data}, {24'd0, exp_data});
    r = rs_in;
    d = lcd_data;
    h = 0;
    stable = 1'b1;
    while (go === 1'b1 && h < 20) begin
      if (rs_in !== r || lcd_data !== d) stable = 1'b0;
      h++;
      @(negedge clk);
    end
    chk({tag, "_hold"}, h, 3);
    chk({tag, "_stable"}, {31'd0, stable}, 32'd1);
  endtask

  task automatic wait_ready(input string tag, input int exp_gap);
    int n;
    logic quiet;
    n = 0;
    quiet = 1'b1;
    while (char_ready !== 1'b1 && n < 100) begin
      if (go === 1'b1) quiet = 1'b0;
      n++;
      @(negedge clk);
    end
    chk({tag, "_gap"}, n, exp_gap);
    chk({tag, "_noxfer"}, {31'd0, quiet}, 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    char_valid = 1'b1;
    char_data  = b;
    @(negedge clk);
    char_valid = 1'b0;
    chk("acc_ready_low", {31'd0, char_ready}, 32'd0);
    chk("acc_go_high", {31'd0, go}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    int gq;

    @(negedge clk);
    chk("rst_go", {31'd0, go}, 32'd0);
    chk("rst_rs", {31'd0, rs_in}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'h00);
    chk("rst_ready", {31'd0, char_ready}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    expect_xfer("init_38", 1'b0, 8'h38, 20);
    expect_xfer("init_0c", 1'b0, 8'h0C, 4);
    expect_xfer("init_06", 1'b0, 8'h06, 4);
    expect_xfer("init_01", 1'b0, 8'h01, 4);
    chk("init_done_early", {31'd0, init_done}, 32'd0);
    wait_ready("init_rdy", 8);
    chk("init_done", {31'd0, init_done}, 32'd1);

    send(8'h41);
    expect_xfer("c41", 1'b1, 8'h41, 0);
    wait_ready("rdy41", 4);

    // 0x43 is presented while busy and must wait for the next ready.
    char_valid = 1'b1;
    char_data  = 8'h42;
    @(negedge clk);
    char_data = 8'h43;
    chk("held_ready_low", {31'd0, char_ready}, 32'd0);
    expect_xfer("c42", 1'b1, 8'h42, 0);
    expect_xfer("c43_held", 1'b1, 8'h43, 5);
    char_valid = 1'b0;

    for (int k = 3; k <= 33; k++) begin
      b = 8'(65 + k);
      wait_ready("rdy", 4);
      send(b);
      if (k == 16) begin
        expect_xfer("line2_cmd", 1'b0, 8'hC0, 0);
        expect_xfer("char17", 1'b1, b, 4);
      end else if (k == 32) begin
        expect_xfer("home_cmd", 1'b0, 8'h80, 0);
        expect_xfer("char33", 1'b1, b, 4);
      end else begin
        expect_xfer("char", 1'b1, b, 0);
      end
    end
    wait_ready("rdy34", 4);

`ifdef LCD_SEQ_CTRL_CHARS_EN
    send(8'h0C);
    expect_xfer("ff_clear", 1'b0, 8'h01, 0);
    wait_ready("ff_rdy", 8);
    send(8'h0D);
    expect_xfer("cr_line2", 1'b0, 8'hC0, 0);
    wait_ready("cr_rdy", 4);
`else
    send(8'h0C);
    expect_xfer("ff_char", 1'b1, 8'h0C, 0);
    wait_ready("ff_rdy", 4);
    send(8'h0D);
    expect_xfer("cr_char", 1'b1, 8'h0D, 0);
    wait_ready("cr_rdy", 4);
`endif

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    gq = 0;
    repeat (5) begin
      if (go !== 1'b0) gq++;
      @(negedge clk);
    end
    chk("spur_no_go", gq, 0);
    chk("spur_ready", {31'd0, char_ready}, 32'd1);

    send(8'h5A);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_go", {31'd0, go}, 32'd0);
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    chk("mid_rst_ready", {31'd0, char_ready}, 32'd0);
    chk("mid_rst_rs", {31'd0, rs_in}, 32'd0);
    chk("mid_rst_data", {24'd0, lcd_data}, 32'h00);
    rst = 1'b0;
    expect_xfer("reinit_38", 1'b0, 8'h38, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
